// File: rtl/udp_tx_arbiter.sv
// Packet-granular arbiter that shares one UDP transmit channel between the video
// packetizer (src0, priority) and the status generator (src1), with a stall watchdog.
module udp_tx_arbiter #(
    parameter int unsigned MAX_S0_BURST = 8,
    parameter logic [15:0] TIMEOUT_CYC  = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [7:0]  s0_data,
    input  logic        s0_last,
    input  logic [15:0] s0_length,
    input  logic        s0_reset,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [7:0]  s1_data,
    input  logic        s1_last,
    input  logic [15:0] s1_length,
    input  logic        s1_reset,
    input  logic        m_ready,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] m_length,
    output logic        m_reset,
    output logic [1:0]  grant,
    output logic [7:0]  abort_cnt
);

    localparam int unsigned LW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [CW-1:0]   burst_q, burst_d;
    logic [LW-1:0]   wd_q, wd_d;
    logic [CW-1:0]   abort_q, abort_d;
    logic            m_reset_q, m_reset_d;

    logic            burst_limit;
    logic            win1;
    logic            sel1;
    logic            sel_any;
    logic            beat;
    logic            abort_pulse;
    logic [LW:0]     wd_inc;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            burst_q   <= '0;
            wd_q      <= '0;
            abort_q   <= '0;
            m_reset_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            wd_q      <= wd_d;
            abort_q   <= abort_d;
            m_reset_q <= m_reset_d;
        end
    end

    // Owner selection and zero-latency datapath mux; everything idles while rst is high
    always_comb begin
        burst_limit = (MAX_S0_BURST != 0) && (32'(burst_q) >= MAX_S0_BURST);
        win1        = (s0_valid && s1_valid) ? burst_limit : s1_valid;
        sel1        = 1'b0;
        sel_any     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        m_length    = '0;
        grant       = '0;
        s0_ready    = 1'b0;
        s1_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                sel_any = s0_valid || s1_valid;
                sel1    = win1;
            end
            LOCK0: begin
                sel_any = 1'b1;
                sel1    = 1'b0;
            end
            LOCK1: begin
                sel_any = 1'b1;
                sel1    = 1'b1;
            end
            default: begin
                sel_any = 1'b0;
            end
        endcase
        if (!rst && sel_any) begin
            m_valid  = sel1 ? s1_valid : s0_valid;
            m_data   = sel1 ? s1_data  : s0_data;
            m_last   = sel1 ? s1_last  : s0_last;
            s0_ready = m_ready && !sel1;
            s1_ready = m_ready && sel1;
            grant    = sel1 ? 2'b10 : 2'b01;
            if (state_q == IDLE) begin
                m_length = sel1 ? s1_length : s0_length;
            end else begin
                m_length = len_q;
            end
        end
    end

    assign beat = m_valid && m_ready;

    // Next-state, burst guard and watchdog
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        burst_d     = burst_q;
        abort_d     = abort_q;
        wd_d        = '0;
        abort_pulse = 1'b0;
        wd_inc      = 17'(wd_q) + 17'd1;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    len_d = m_length;
                    if (!m_last) begin
                        state_d = sel1 ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                // A beat in the expiry cycle takes precedence over the abort
                if (beat) begin
                    if (m_last) begin
                        state_d = IDLE;
                    end
                end else if (wd_inc >= 17'(TIMEOUT_CYC)) begin
                    abort_pulse = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wd_d = wd_inc[LW-1:0];
                end
                if ((state_q == LOCK0 && s0_reset) || (state_q == LOCK1 && s1_reset)) begin
                    state_d = IDLE;
                    wd_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (beat && m_last && !sel1 && s1_valid) begin
            if (burst_q != 8'hFF) begin
                burst_d = burst_q + 8'd1;
            end
        end else if (beat && sel1 && state_q == IDLE) begin
            burst_d = '0;
        end
        if (abort_pulse && abort_q != 8'hFF) begin
            abort_d = abort_q + 8'd1;
        end
        m_reset_d = s0_reset || s1_reset || abort_pulse;
    end

    assign m_reset   = m_reset_q;
    assign abort_cnt = abort_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: randomized packet streams checked against a
// packet-level arbitration model, plus directed watchdog/reset cases.
module tb_udp_tx_arbiter;

    localparam int MAXB = 8;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic [15:0] len;
    } beat_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s0_valid, s0_ready, s0_last, s0_reset;
    logic [7:0]  s0_data;
    logic [15:0] s0_length;
    logic        s1_valid, s1_ready, s1_last, s1_reset;
    logic [7:0]  s1_data;
    logic [15:0] s1_length;
    logic        m_ready, m_valid, m_last, m_reset;
    logic [7:0]  m_data, abort_cnt;
    logic [15:0] m_length;
    logic [1:0]  grant;

    logic        z_rst;
    logic        z_s0_valid, z_s0_ready, z_s0_last, z_s0_reset;
    logic [7:0]  z_s0_data;
    logic [15:0] z_s0_length;
    logic        z_s1_valid, z_s1_ready, z_s1_last, z_s1_reset;
    logic [7:0]  z_s1_data;
    logic [15:0] z_s1_length;
    logic        z_m_ready, z_m_valid, z_m_last, z_m_reset;
    logic [7:0]  z_m_data, z_abort_cnt;
    logic [15:0] z_m_length;
    logic [1:0]  z_grant;

    udp_tx_arbiter #(.MAX_S0_BURST(MAXB), .TIMEOUT_CYC(16'd4096)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
        .s0_length(s0_length), .s0_reset(s0_reset),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
        .s1_length(s1_length), .s1_reset(s1_reset),
        .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_length(m_length), .m_reset(m_reset), .grant(grant), .abort_cnt(abort_cnt)
    );

    udp_tx_arbiter #(.MAX_S0_BURST(0), .TIMEOUT_CYC(16'd4096)) dut_z (
        .clk(clk), .rst(z_rst),
        .s0_valid(z_s0_valid), .s0_ready(z_s0_ready), .s0_data(z_s0_data), .s0_last(z_s0_last),
        .s0_length(z_s0_length), .s0_reset(z_s0_reset),
        .s1_valid(z_s1_valid), .s1_ready(z_s1_ready), .s1_data(z_s1_data), .s1_last(z_s1_last),
        .s1_length(z_s1_length), .s1_reset(z_s1_reset),
        .m_ready(z_m_ready), .m_valid(z_m_valid), .m_data(z_m_data), .m_last(z_m_last),
        .m_length(z_m_length), .m_reset(z_m_reset), .grant(z_grant), .abort_cnt(z_abort_cnt)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t drv0[$], drv1[$], exp0[$], exp1[$];
    int    pkt_log[$];
    logic  fire0 = 1'b0, fire1 = 1'b0;
    logic  auto_en = 1'b0, mon_en = 1'b0, gap_en = 1'b0;
    int    rdy_mode = 1;
    int    in_pkt = 0, owner = 0, burst = 0;
    int    beats = 0, first_beat = -1, last_beat = -1, cyc = 0, mres_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_valid = 0; s0_data = 0; s0_last = 0; s0_length = 0; s0_reset = 0;
        s1_valid = 0; s1_data = 0; s1_last = 0; s1_length = 0; s1_reset = 0;
        m_ready  = 0;
    endtask

    task automatic rst_dut();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
        in_pkt = 0; burst = 0; beats = 0; first_beat = -1; last_beat = -1; mres_cnt = 0;
        pkt_log.delete();
    endtask

    task automatic add_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom);
            b.last = (i == len - 1);
            b.len  = 16'(len);
            if (src == 0) begin
                drv0.push_back(b); exp0.push_back(b);
            end else begin
                drv1.push_back(b); exp1.push_back(b);
            end
        end
    endtask

    task automatic run_auto(input int mode, input logic gaps, input int maxc);
        int n = 0;
        rdy_mode = mode; gap_en = gaps; mon_en = 1; auto_en = 1;
        while ((exp0.size() > 0 || exp1.size() > 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (exp0.size() > 0 || exp1.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d/%0d beats left after %0d cycles", exp0.size(), exp1.size(), n);
        end
        @(posedge clk);
        #2;
        auto_en = 0; mon_en = 0;
        clear_inputs();
        drv0.delete(); drv1.delete(); exp0.delete(); exp1.delete();
    endtask

    // Source and sink drivers: present queue heads, advance on handshake
    always @(posedge clk) begin
        #1;
        if (auto_en) begin
            if (fire0 && drv0.size() > 0) void'(drv0.pop_front());
            if (fire1 && drv1.size() > 0) void'(drv1.pop_front());
            case (rdy_mode)
                0:       m_ready = ($urandom_range(0, 3) != 0);
                1:       m_ready = 1'b1;
                default: m_ready = !m_ready;
            endcase
            if (drv0.size() > 0) begin
                s0_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                s0_data = drv0[0].data; s0_last = drv0[0].last; s0_length = drv0[0].len;
            end else begin
                s0_valid = 1'b0;
            end
            if (drv1.size() > 0) begin
                s1_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                s1_data = drv1[0].data; s1_last = drv1[0].last; s1_length = drv1[0].len;
            end else begin
                s1_valid = 1'b0;
            end
        end
    end

    // Monitor: packet-level arbitration model + per-source expected byte queues
    always @(negedge clk) begin : mon
        beat_t b;
        logic [1:0] eg;
        fire0 = s0_valid && s0_ready;
        fire1 = s1_valid && s1_ready;
        cyc++;
        if (mon_en) begin
            if (m_reset) mres_cnt++;
            if (m_valid && m_ready) begin
                if (in_pkt == 0) begin
                    if (s0_valid && !s1_valid)      owner = 0;
                    else if (!s0_valid && s1_valid) owner = 1;
                    else                            owner = (burst >= MAXB) ? 1 : 0;
                    if (owner == 1) burst = 0;
                end
                eg = (owner == 1) ? 2'b10 : 2'b01;
                check("grant", 64'(grant), 64'(eg));
                check("src_ready", 64'({s1_ready, s0_ready}), 64'(eg));
                if ((owner == 0 && exp0.size() == 0) || (owner == 1 && exp1.size() == 0)) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_beat: src %0d data %0h with nothing expected", owner, m_data);
                end else begin
                    if (owner == 0) b = exp0.pop_front();
                    else            b = exp1.pop_front();
                    check("m_data", 64'(m_data), 64'(b.data));
                    check("m_last", 64'(m_last), 64'(b.last));
                    check("m_length", 64'(m_length), 64'(b.len));
                end
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                if (m_last) begin
                    in_pkt = 0;
                    pkt_log.push_back(owner);
                    if (owner == 0 && s1_valid && burst < 255) burst++;
                end else begin
                    in_pkt = 1;
                end
            end else if (in_pkt != 0) begin
                eg = (owner == 1) ? 2'b10 : 2'b01;
                check("grant_hold", 64'(grant), 64'(eg));
            end
        end
    end

    initial begin
        int cnt;
        int first1;
        logic [7:0] zc;
        rst = 1; clear_inputs();
        z_rst = 1; z_s0_valid = 0; z_s0_data = 0; z_s0_last = 0; z_s0_length = 0; z_s0_reset = 0;
        z_s1_valid = 0; z_s1_data = 0; z_s1_last = 0; z_s1_length = 0; z_s1_reset = 0; z_m_ready = 0;

        // Reset holds every output at its reset value even with busy inputs
        s0_valid = 1; s1_valid = 1; m_ready = 1; s0_reset = 1; s0_data = 8'hFF; s0_length = 16'd77;
        tick(); tick();
        @(negedge clk);
        check("reset_outputs", 64'({m_valid, m_last, m_reset, s0_ready, s1_ready, grant, m_data, m_length, abort_cnt}), 64'd0);

        // src0 alone: three 1282-byte packets
        rst_dut();
        for (int i = 0; i < 3; i++) add_pkt(0, 1282);
        run_auto(1, 1'b0, 5000);
        check("t1_beats", 64'(beats), 64'd3846);
        check("t1_pkts", 64'(pkt_log.size()), 64'd3);
        check("t1_no_mreset", 64'(mres_cnt), 64'd0);

        // starvation guard: src1 waits exactly MAX_S0_BURST src0 packets
        rst_dut();
        for (int i = 0; i < 10; i++) add_pkt(0, 5);
        add_pkt(1, 64);
        run_auto(1, 1'b0, 2000);
        first1 = -1;
        for (int i = 0; i < pkt_log.size(); i++) if (first1 < 0 && pkt_log[i] == 1) first1 = i;
        check("t2_pkts", 64'(pkt_log.size()), 64'd11);
        check("t2_src1_slot", 64'(first1), 64'(MAXB));

        // m_ready toggling every cycle during a 10-byte packet
        rst_dut();
        add_pkt(0, 10);
        run_auto(2, 1'b0, 100);
        check("t5_beats", 64'(beats), 64'd10);
        check("t5_span", 64'(last_beat - first_beat), 64'd18);
        check("t5_no_mreset", 64'(mres_cnt), 64'd0);
        check("t5_abort_cnt", 64'(abort_cnt), 64'd0);

        // randomized traffic from both sources with gaps and backpressure
        rst_dut();
        for (int i = 0; i < 40; i++) add_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        run_auto(0, 1'b1, 6000);
        check("rand_pkts", 64'(pkt_log.size()), 64'd40);
        check("rand_no_mreset", 64'(mres_cnt), 64'd0);
        check("rand_abort_cnt", 64'(abort_cnt), 64'd0);

        // watchdog: lock src1 then stall it
        rst_dut();
        s1_valid = 1; s1_data = 8'hA5; s1_last = 0; s1_length = 16'd10; m_ready = 1;
        @(negedge clk);
        check("wd_first_grant", 64'(grant), 64'h2);
        check("wd_first_data", 64'(m_data), 64'hA5);
        tick();
        s1_valid = 0; s0_valid = 1; s0_last = 1; s0_data = 8'h3C; s0_length = 16'd1;
        @(negedge clk);
        cnt = 1;
        check("wd_lock_grant", 64'(grant), 64'h2);
        check("wd_s0_blocked", 64'(s0_ready), 64'd0);
        while (!m_reset && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("wd_fired", 64'(m_reset), 64'd1);
        n_tests++;
        if (cnt < 4096 || cnt > 4098) begin
            n_fail++;
            $display("FAIL wd_latency: abort after %0d stalled cycles expected about 4096", cnt);
        end
        check("wd_abort_cnt", 64'(abort_cnt), 64'd1);
        check("wd_src0_next", 64'(grant), 64'h1);
        check("wd_src0_ready", 64'(s0_ready), 64'd1);
        tick();
        s0_valid = 0;
        @(negedge clk);
        check("wd_pulse_width", 64'(m_reset), 64'd0);

        // rst in the middle of a locked src0 packet
        s0_valid = 1; s0_last = 0; s0_data = 8'h55; s0_length = 16'd9;
        tick();
        rst = 1; s0_reset = 1; s1_valid = 1; s1_last = 1; s1_length = 16'd3;
        @(negedge clk);
        check("rst_comb_gate", 64'(m_valid), 64'd0);
        tick();
        @(negedge clk);
        check("rst_mid_outputs", 64'({m_valid, m_last, m_reset, s0_ready, s1_ready, grant, m_data, m_length, abort_cnt}), 64'd0);
        rst = 0; s0_reset = 0; s0_valid = 0;
        @(negedge clk);
        check("rst_back_idle", 64'(grant), 64'h2);
        check("rst_no_mreset", 64'(m_reset), 64'd0);

        // owner reset inside LOCK0 releases the channel
        rst_dut();
        m_ready = 1; s0_valid = 1; s0_last = 0; s0_data = 8'h11; s0_length = 16'd20;
        tick();
        s0_reset = 1; s0_valid = 0; s1_valid = 1; s1_last = 1; s1_data = 8'h22; s1_length = 16'd7;
        @(negedge clk);
        check("s0rst_locked", 64'({grant, s1_ready}), 64'h2);
        tick();
        s0_reset = 0;
        @(negedge clk);
        check("s0rst_mreset", 64'(m_reset), 64'd1);
        check("s0rst_idle_grant", 64'(grant), 64'h2);
        check("s0rst_idle_len", 64'(m_length), 64'd7);
        tick();
        s1_valid = 0;
        @(negedge clk);
        check("s0rst_pulse_width", 64'(m_reset), 64'd0);

        // non-owner reset pulses m_reset but keeps the lock
        s0_valid = 1; s0_last = 0; s0_data = 8'h33; s0_length = 16'd4;
        tick();
        s1_reset = 1; s1_valid = 1; s1_last = 1; s0_valid = 0;
        tick();
        s1_reset = 0;
        @(negedge clk);
        check("s1rst_mreset", 64'(m_reset), 64'd1);
        check("s1rst_hold_grant", 64'(grant), 64'h1);
        check("s1rst_s1_blocked", 64'(s1_ready), 64'd0);
        s1_valid = 0; s0_valid = 1; s0_last = 1;
        tick();
        s0_valid = 0;

        // strict src0 priority instance: src1 never granted, no idle gaps
        z_rst = 1; tick(); tick(); z_rst = 0;
        z_s0_valid = 1; z_s1_valid = 1; z_s1_last = 1; z_s1_length = 16'd8; z_m_ready = 1; z_s0_length = 16'd4;
        zc = 8'd0;
        for (int i = 0; i < 200; i++) begin
            z_s0_data = zc;
            z_s0_last = (zc[1:0] == 2'b11);
            @(negedge clk);
            check("strict_prio", 64'({z_m_valid, z_grant, z_s1_ready}), 64'hA);
            check("strict_data", 64'(z_m_data), 64'(zc));
            @(posedge clk);
            #1;
            zc = zc + 8'd1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit channel toward the Ethernet UDP/IP stack between two packet sources.
  - Source 0 is the video line packetizer (RGB-to-UDP).
  - Source 1 is a low-rate status/telemetry packet generator.
- Arbitrates at packet granularity with priority to source 0, a starvation guard for source 1, and a stall watchdog that aborts a hung packet.
- Sits between the packet sources and the UDP stack transmit port.

Parameters:
- MAX_S0_BURST, 8: consecutive source-0 packets allowed while source 1 waits; 0 = strict source-0 priority.
- TIMEOUT_CYC, 16'd4096: idle cycles inside a locked packet before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s0_valid  in  1  source 0 byte valid.
- s0_ready  out  1  source 0 byte accepted.
- s0_data  in  8  source 0 byte.
- s0_last  in  1  source 0 last byte of packet.
- s0_length  in  16  source 0 UDP payload length, stable from first byte to last byte.
- s0_reset  in  1  source 0 channel reset request (pulse).
- s1_valid, s1_ready, s1_data, s1_last, s1_length, s1_reset: same as the source 0 ports, for source 1.
- m_ready  in  1  stack accepts byte.
- m_valid  out  1  byte valid to stack.
- m_data  out  8  byte to stack.
- m_last  out  1  last byte to stack.
- m_length  out  16  payload length of current packet.
- m_reset  out  1  reset pulse to stack.
- grant  out  2  one-hot current/next owner: bit0 = src0, bit1 = src1.
- abort_cnt  out  8  saturating count of watchdog aborts.

Behaviour:
- Reset values:
  - State IDLE; m_valid, m_last, m_reset, s0_ready, s1_ready = 0.
  - m_data = 0, m_length = 0, grant = 0, abort_cnt = 0.
  - Burst counter and timeout counter = 0.
  - While rst is high, all datapath outputs are forced to these values regardless of inputs.
- Beat transfer: a beat transfers when m_valid && m_ready. The datapath is a zero-latency combinational mux of the selected source.
  - m_valid = sel_valid; m_data = sel_data; m_last = sel_last; sN_ready = m_ready && (sel == N).
  - Unselected source ready = 0.
- States: IDLE, LOCK0, LOCK1.
- IDLE winner selection (combinational, from the valid inputs):
  - Only one source valid: that source wins.
  - Both valid: src1 wins if MAX_S0_BURST != 0 and burst_cnt >= MAX_S0_BURST; otherwise src0 wins.
  - grant shows the winner; m_length = winner's sN_length.
  - On a first-beat transfer, latch winner length into len_q.
  - If the first beat is not last, go to LOCKn.
  - A single-beat packet (first beat is last) stays in IDLE.
  - If no beat transfers (m_ready = 0), nothing is locked; the winner may change next cycle.
- LOCKn:
  - sel = n; m_length = len_q; the other source is ignored until the packet ends.
  - A transfer with m_last returns to IDLE on the next cycle.
  - Ownership never changes mid-packet, even if the other source has higher priority.
- Burst counter (8-bit, saturating at 255):
  - Increments on each completed src0 packet (last beat) while s1_valid is high.
  - Clears on the first accepted src1 beat.
  - Holds otherwise.
- Watchdog (16-bit counter, active only in LOCKn):
  - Clears on every transferred beat and on entry to LOCKn; otherwise increments.
  - At TIMEOUT_CYC: one-cycle m_reset pulse, return to IDLE, abort_cnt += 1 (saturating at 255), timeout counter cleared.
  - The aborted source's remaining bytes then compete as a new packet.
- Source resets:
  - m_reset = s0_reset | s1_reset | abort_pulse, registered (1-cycle latency), one cycle wide per cycle of request.
  - If sN_reset is asserted while in LOCKn for the same n, return to IDLE the next cycle without waiting for last.
  - A reset from the non-owning source does not change the state.
- Simultaneous events:
  - Watchdog expiry and a beat in the same cycle: the beat wins and the counter clears.
  - m_last transfer and sN_reset in the same cycle: go to IDLE; m_reset still pulses.
- Width rules: all counters saturate, none wrap; len_q is 16 bits, passed unchanged.

Test Plan:
1. Only src0 sends 3 packets of 1282 bytes with m_ready = 1 → 3846 beats out in order, m_length = 1282 throughout, grant = 01, s1_ready = 0.
2. src1 asserts valid (length 64) during a src0 packet → src1 stalls until src0 last; src0 keeps priority while burst_cnt < 8; after the 8th src0 packet the next packet is src1 (64 beats), then burst_cnt = 0.
3. MAX_S0_BURST = 0 with both sources valid continuously → src1 never granted; src0 packets run back-to-back with no idle gap.
4. Lock src1, then drop s1_valid for 4096 cycles → m_reset high for exactly 1 cycle, abort_cnt = 1, state IDLE, pending src0 granted the next cycle.
5. m_ready toggles 1/0 every cycle during a 10-byte src0 packet → 10 beats over 20 cycles, data matches, and the watchdog never fires.
6. s0_reset mid-LOCK0, and separately rst mid-packet → m_reset pulse (the s0_reset case only) and return to IDLE; under rst all outputs are at reset values in the following cycle.
